// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator with edge-replicated borders, feeding the Sobel datapath.
// Two line buffers hold the previous two rows; two column registers plus the incoming column form each window.
module sobel_window_gen #(
  parameter int WIDTH  = 5,
  parameter int HEIGHT = 5,
  parameter int PIX_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [PIX_W-1:0]          s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [9*PIX_W-1:0]        m_win,
  output logic [$clog2(HEIGHT)-1:0] m_row,
  output logic [$clog2(WIDTH)-1:0]  m_col,
  output logic                      m_last,
  output logic                      busy
);
  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;
  typedef logic [2:0][PIX_W-1:0] col_t;  // [0]=top, [1]=centre, [2]=bottom row

  function automatic logic [9*PIX_W-1:0] pack_win(input col_t c0, input col_t c1, input col_t c2);
    logic [9*PIX_W-1:0] w;
    for (int k = 0; k < 3; k++) begin
      w[(3*k+0)*PIX_W +: PIX_W] = c0[k];
      w[(3*k+1)*PIX_W +: PIX_W] = c1[k];
      w[(3*k+2)*PIX_W +: PIX_W] = c2[k];
    end
    return w;
  endfunction

  state_t             state_q, state_d;
  logic               rdy_en_q;
  logic [RW-1:0]      in_row_q, in_row_d, out_row_q, out_row_d, m_row_q, m_row_d;
  logic [CW-1:0]      in_col_q, in_col_d, out_col_q, out_col_d, m_col_q, m_col_d;
  logic [CW-1:0]      fl_col_q, fl_col_d;
  logic               fl_done_q, fl_done_d, pend_q, pend_d;
  logic               m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [9*PIX_W-1:0] m_win_q, m_win_d;
  logic [PIX_W-1:0]   lb_top_q [WIDTH];
  logic [PIX_W-1:0]   lb_mid_q [WIDTH];
  col_t               sw1_q, sw2_q, new_col;

  logic          flushing, out_free, has_row, need_out, in_ok, in_acc, fl_go;
  logic          load, emit_pend, emit_src, emit, in_last;
  logic [CW-1:0] col_idx;

  // A column source is either the input pixel stream or, after the last pixel, a replay of the
  // line buffers with the bottom row replicated. pend_q marks the right-border window that still
  // has to be emitted after a row's last column has been loaded.
  always_comb begin
    flushing   = (state_q == FLUSH);
    col_idx    = flushing ? fl_col_q : in_col_q;
    has_row    = flushing || (in_row_q != '0);
    out_free   = !m_valid_q || m_ready;
    need_out   = pend_q || (has_row && (col_idx != '0));
    in_ok      = rdy_en_q && !flushing && (!need_out || out_free);
    in_acc     = s_valid && in_ok;
    fl_go      = flushing && !fl_done_q && (!need_out || out_free);
    load       = (in_acc || fl_go) && has_row;
    emit_pend  = pend_q && out_free;
    emit_src   = load && (col_idx != '0);
    emit       = emit_pend || emit_src;
    in_last    = (in_row_q == ROW_MAX) && (in_col_q == COL_MAX);
    new_col[0] = (!flushing && (in_row_q == RW'(1))) ? lb_mid_q[col_idx] : lb_top_q[col_idx];
    new_col[1] = lb_mid_q[col_idx];
    new_col[2] = flushing ? lb_mid_q[col_idx] : s_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_acc) state_d = FILL;
      FILL:    if (in_acc && (in_row_q == RW'(1)) && (in_col_q == CW'(1))) state_d = STREAM;
      STREAM:  if (in_acc && in_last) state_d = FLUSH;
      FLUSH:   if (m_valid_q && m_ready && m_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_row_d  = in_row_q;
    in_col_d  = in_col_q;
    fl_col_d  = fl_col_q;
    fl_done_d = fl_done_q;
    pend_d    = pend_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    m_valid_d = m_valid_q && !m_ready;
    m_win_d   = m_win_q;
    m_row_d   = m_row_q;
    m_col_d   = m_col_q;
    m_last_d  = m_last_q;
    if (in_acc) begin
      if (in_col_q == COL_MAX) begin
        in_col_d = '0;
        in_row_d = (in_row_q == ROW_MAX) ? '0 : in_row_q + RW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end
    if (!flushing) begin
      fl_col_d  = '0;
      fl_done_d = 1'b0;
    end else if (fl_go) begin
      if (fl_col_q == COL_MAX) fl_done_d = 1'b1;
      else                     fl_col_d  = fl_col_q + CW'(1);
    end
    if (emit_pend) pend_d = 1'b0;
    if (load && (col_idx == COL_MAX)) pend_d = 1'b1;
    if (emit) begin
      m_valid_d = 1'b1;
      m_win_d   = emit_pend ? pack_win(sw1_q, sw2_q, sw2_q) : pack_win(sw1_q, sw2_q, new_col);
      m_row_d   = out_row_q;
      m_col_d   = out_col_q;
      m_last_d  = (out_row_q == ROW_MAX) && (out_col_q == COL_MAX);
      if (out_col_q == COL_MAX) begin
        out_col_d = '0;
        out_row_d = (out_row_q == ROW_MAX) ? '0 : out_row_q + RW'(1);
      end else begin
        out_col_d = out_col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rdy_en_q  <= 1'b0;
      in_row_q  <= '0;
      in_col_q  <= '0;
      fl_col_q  <= '0;
      fl_done_q <= 1'b0;
      pend_q    <= 1'b0;
      out_row_q <= '0;
      out_col_q <= '0;
      m_valid_q <= 1'b0;
      m_win_q   <= '0;
      m_row_q   <= '0;
      m_col_q   <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_en_q  <= 1'b1;
      in_row_q  <= in_row_d;
      in_col_q  <= in_col_d;
      fl_col_q  <= fl_col_d;
      fl_done_q <= fl_done_d;
      pend_q    <= pend_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      m_valid_q <= m_valid_d;
      m_win_q   <= m_win_d;
      m_row_q   <= m_row_d;
      m_col_q   <= m_col_d;
      m_last_q  <= m_last_d;
    end
  end

  // Column 0 fills both stored columns so the left border replicates without a special case.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      lb_top_q[in_col_q] <= lb_mid_q[in_col_q];
      lb_mid_q[in_col_q] <= s_data;
    end
    if (load) begin
      if (col_idx == '0) begin
        sw1_q <= new_col;
        sw2_q <= new_col;
      end else begin
        sw1_q <= sw2_q;
        sw2_q <= new_col;
      end
    end
  end

  assign s_ready = in_ok;
  assign m_valid = m_valid_q;
  assign m_win   = m_win_q;
  assign m_row   = m_row_q;
  assign m_col   = m_col_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: expected windows come from a clamp-indexed frame model.
module tb_sobel_window_gen;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int PW = 32;
  localparam int WW = 9 * PW;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n, s_valid, s_ready, m_valid, m_ready, m_last, busy;
  logic [PW-1:0] s_data;
  logic [WW-1:0] m_win;
  logic [RW-1:0] m_row;
  logic [CW-1:0] m_col;

  always #5 clk = ~clk;

  sobel_window_gen #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_win(m_win), .m_row(m_row), .m_col(m_col),
    .m_last(m_last), .busy(busy)
  );

  typedef struct {
    logic [WW-1:0] win;
    int            row;
    int            col;
    bit            last;
    int            kind;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            mr_rand = 0;
  bit            frame_active = 0;
  bit            flushing = 0;
  logic [PW-1:0] frame [H][W];

  function automatic int clampi(input int x, input int hi);
    return (x < 0) ? 0 : ((x > hi) ? hi : x);
  endfunction

  function automatic logic [WW-1:0] pk(input int v0, input int v1, input int v2, input int v3,
                                       input int v4, input int v5, input int v6, input int v7,
                                       input int v8);
    logic [WW-1:0] w;
    int v[9];
    v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    for (int i = 0; i < 9; i++) w[i*PW +: PW] = PW'(v[i]);
    return w;
  endfunction

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // kind 1: row ramp 10*(r+1); kind 2: 5r+c; kind 3: random pixels
  task automatic build_and_expect(input int kind);
    exp_t e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame[r][c] = (kind == 1) ? PW'(10 * (r + 1)) : (kind == 2) ? PW'(5 * r + c) : PW'($urandom());
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        for (int k = 0; k < 3; k++)
          for (int l = 0; l < 3; l++)
            e.win[(3*k+l)*PW +: PW] = frame[clampi(r - 1 + k, H - 1)][clampi(c - 1 + l, W - 1)];
        e.row  = r;
        e.col  = c;
        e.last = (r == H - 1) && (c == W - 1);
        e.kind = kind;
        exp_q.push_back(e);
      end
  endtask

  task automatic send_pixel(input logic [PW-1:0] d, input bit gaps);
    int n;
    if (gaps && ($urandom_range(0, 1) == 1))
      repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 2000) begin @(negedge clk); n++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: s_ready stayed %0b, expected 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int kind, input bit gaps, input int npix);
    build_and_expect(kind);
    for (int i = 0; i < npix; i++) begin
      send_pixel(frame[i / W][i % W], gaps);
      if (i == 0) frame_active = 1;
      if (i == W * H - 1) flushing = 1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || frame_active) && n < 5000) begin @(posedge clk); #1; n++; end
    chk({name, "_drain_left"}, WW'(exp_q.size()), '0);
    chk({name, "_busy_after"}, WW'(busy), '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, WW'(s_ready), '0);
    chk({tag, "_m_valid"}, WW'(m_valid), '0);
    chk({tag, "_m_win"}, m_win, '0);
    chk({tag, "_m_row"}, WW'(m_row), '0);
    chk({tag, "_m_col"}, WW'(m_col), '0);
    chk({tag, "_m_last"}, WW'(m_last), '0);
    chk({tag, "_busy"}, WW'(busy), '0);
  endtask

  initial begin : ready_drv
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = mr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin : monitor
    exp_t          e;
    bit            stalled;
    logic [WW-1:0] h_win;
    logic [RW-1:0] h_row;
    logic [CW-1:0] h_col;
    logic          h_last;
    stalled = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0;
        continue;
      end
      if (stalled) begin
        checks++;
        if (!(m_valid && m_win == h_win && m_row == h_row && m_col == h_col && m_last == h_last)) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b r=%0d c=%0d last=%0b win=%h, expected held r=%0d c=%0d last=%0b win=%h",
                   m_valid, m_row, m_col, m_last, m_win, h_row, h_col, h_last, h_win);
        end
      end
      if (flushing) chk("flush_s_ready", WW'(s_ready), '0);
      if (frame_active) chk("busy_in_frame", WW'(busy), WW'(1));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_window: got r=%0d c=%0d, expected none", m_row, m_col);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (m_win !== e.win || m_row !== RW'(e.row) || m_col !== CW'(e.col) || m_last !== e.last) begin
            errors++;
            $display("FAIL window: got r=%0d c=%0d last=%0b win=%h, expected r=%0d c=%0d last=%0b win=%h",
                     m_row, m_col, m_last, m_win, e.row, e.col, e.last, e.win);
          end
          if (e.kind == 1 && e.row == 0 && e.col == 0) chk("T1_w00", m_win, pk(10, 10, 10, 10, 10, 10, 20, 20, 20));
          if (e.kind == 1 && e.row == 2 && e.col == 2) chk("T1_w22", m_win, pk(20, 20, 20, 30, 30, 30, 40, 40, 40));
          if (e.kind == 1 && e.row == 4 && e.col == 4) chk("T1_w44", m_win, pk(40, 40, 40, 50, 50, 50, 50, 50, 50));
          if (e.kind == 2 && e.row == 4 && e.col == 0) chk("T2_w40", m_win, pk(15, 15, 16, 20, 20, 21, 20, 20, 21));
          if (e.kind == 2 && e.row == 0 && e.col == 0) chk("T2_w00", m_win, pk(0, 0, 1, 0, 0, 1, 5, 5, 6));
          if (e.last) begin
            frame_active = 0;
            flushing     = 0;
          end
        end
      end
      stalled = m_valid && !m_ready;
      h_win = m_win; h_row = m_row; h_col = m_col; h_last = m_last;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("por_s_ready_rise", WW'(s_ready), WW'(1));

    send_frame(1, 0, W * H);  wait_drain("T1");
    send_frame(2, 0, W * H);  wait_drain("T2");
    mr_rand = 1;
    send_frame(2, 0, W * H);  wait_drain("T3");
    mr_rand = 0;
    send_frame(2, 1, W * H);  wait_drain("T4");

    send_frame(2, 0, 12);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    frame_active = 0;
    flushing     = 0;
    check_reset_outputs("T5_rst");
    @(posedge clk); #1;
    chk("T5_s_ready_rise", WW'(s_ready), WW'(1));
    send_frame(1, 0, W * H);  wait_drain("T5");

    send_frame(1, 0, W * H);
    send_frame(2, 0, W * H);  wait_drain("T6");

    mr_rand = 1;
    for (int f = 0; f < 3; f++) begin
      send_frame(3, 1, W * H);
      wait_drain("T7");
    end
    mr_rand = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
